// File: rtl/mixer_sequencer.sv
// Frame sequencer: polls voices 0..NUM_VOICES-1 per tick, pushes each sample into the mixer, hands the mix downstream.
// Optional build macro MIXER_SEQ_MUTE_MASK_EN adds i_mute, a per-slot mask that skips the voice request and pushes zero.
module mixer_sequencer #(
  parameter int NUM_VOICES  = 10,
  parameter int DATA_W      = 24,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tick,
  output logic                  o_voice_req,
  output logic [3:0]            o_voice_idx,
  input  logic                  i_voice_valid,
  input  logic [DATA_W-1:0]     i_voice_data,
  output logic                  o_mix_en,
  output logic [DATA_W-1:0]     o_mix_data,
  input  logic                  i_mix_rdy,
  input  logic [DATA_W-1:0]     i_mix_out,
  output logic [DATA_W-1:0]     o_sample,
  output logic                  o_sample_valid,
  input  logic                  i_sample_ready,
  output logic                  o_busy,
  output logic                  o_timeout,
  output logic                  o_overrun,
  input  logic                  i_clr_err,
`ifdef MIXER_SEQ_MUTE_MASK_EN
  input  logic [NUM_VOICES-1:0] i_mute,
`endif
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_PUSH  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX    = 4'(NUM_VOICES - 1);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         cnt_inc;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;
  logic               timeout_set;
  logic               overrun_set;
  logic               slot_muted;

`ifdef MIXER_SEQ_MUTE_MASK_EN
  assign slot_muted = i_mute[idx_q];
`else
  assign slot_muted = 1'b0;
`endif

  // Output handshake: o_sample/o_sample_valid hold until i_sample_ready is
  // sampled high while valid; a new result loaded while still valid and not
  // being accepted overwrites the old one and raises o_overrun.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    timeout_set    = 1'b0;
    overrun_set    = 1'b0;
    cnt_inc        = cnt_q + 8'd1;

    if (sample_valid_q && i_sample_ready) begin
      sample_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (i_tick) begin
          state_d = S_REQ;
          idx_d   = 4'd0;
        end
      end
      S_REQ: begin
        cnt_d = 8'd0;
        if (slot_muted) begin
          data_d  = '0;
          state_d = S_PUSH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_voice_valid) begin
          data_d  = i_voice_data;
          state_d = S_PUSH;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_LIM) begin
            data_d      = '0;
            timeout_set = 1'b1;
            state_d     = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (i_mix_rdy) begin
          sample_d       = i_mix_out;
          sample_valid_d = 1'b1;
          overrun_set    = sample_valid_q && !i_sample_ready;
          state_d        = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The tick is seen by the state register, so a tick on the DRAIN->IDLE edge is dropped too.
    if (i_tick && (state_q != S_IDLE)) begin
      overrun_set = 1'b1;
    end

    timeout_d = timeout_q;
    overrun_d = overrun_q;
    if (i_clr_err) begin
      timeout_d = 1'b0;
      overrun_d = 1'b0;
    end
    if (timeout_set) timeout_d = 1'b1;
    if (overrun_set) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= 4'd0;
      cnt_q          <= 8'd0;
      data_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      data_q         <= data_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      timeout_q      <= timeout_d;
      overrun_q      <= overrun_d;
    end
  end

  assign o_voice_req    = (state_q == S_REQ) && !slot_muted;
  assign o_voice_idx    = idx_q;
  assign o_mix_en       = (state_q == S_PUSH);
  assign o_mix_data     = data_q;
  assign o_sample       = sample_q;
  assign o_sample_valid = sample_valid_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_timeout      = timeout_q;
  assign o_overrun      = overrun_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_mixer_sequencer.sv
// Bench for mixer_sequencer: voice-engine and mixer models at the negedge, directed and random frames
// checked against a per-frame timing/sum reference computed from the frame table.
`timescale 1ns/1ps
module tb_mixer_sequencer;
  localparam int NV = 10;
  localparam int DW = 24;
  localparam int TO = 15;

  logic          clk;
  logic          rst;
  logic          i_tick;
  logic          o_voice_req;
  logic [3:0]    o_voice_idx;
  logic          i_voice_valid;
  logic [DW-1:0] i_voice_data;
  logic          o_mix_en;
  logic [DW-1:0] o_mix_data;
  logic          i_mix_rdy;
  logic [DW-1:0] i_mix_out;
  logic [DW-1:0] o_sample;
  logic          o_sample_valid;
  logic          i_sample_ready;
  logic          o_busy;
  logic          o_timeout;
  logic          o_overrun;
  logic          i_clr_err;
  logic [2:0]    o_dbg_state;
  logic [NV-1:0] vmute = '0;

  mixer_sequencer #(.NUM_VOICES(NV), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_tick         (i_tick),
    .o_voice_req    (o_voice_req),
    .o_voice_idx    (o_voice_idx),
    .i_voice_valid  (i_voice_valid),
    .i_voice_data   (i_voice_data),
    .o_mix_en       (o_mix_en),
    .o_mix_data     (o_mix_data),
    .i_mix_rdy      (i_mix_rdy),
    .i_mix_out      (i_mix_out),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid),
    .i_sample_ready (i_sample_ready),
    .o_busy         (o_busy),
    .o_timeout      (o_timeout),
    .o_overrun      (o_overrun),
    .i_clr_err      (i_clr_err),
`ifdef MIXER_SEQ_MUTE_MASK_EN
    .i_mute         (vmute),
`endif
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- frame table and scoreboard ----------------
  int            vlat[NV];
  logic [DW-1:0] vdata[NV];
  logic [31:0]   exp_q[$];
  int            en_q[$];
  int            ncyc = 0;
  int            valid_rise = -1;
  int            req_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  // Voice engine answers after vlat cycles (valid in first WAIT cycle when 0);
  // mixer accumulates sample>>>4 and strobes rdy the cycle after its 10th enable.
  initial begin
    int vcnt;
    int vidx;
    int ecnt;
    bit rdy_pend;
    bit prev_v;
    logic signed [DW-1:0] acc;
    logic signed [DW-1:0] sh;
    vcnt = -1; vidx = 0; ecnt = 0; rdy_pend = 0; prev_v = 0; acc = '0;
    i_voice_valid = 0; i_voice_data = '0; i_mix_rdy = 0; i_mix_out = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      i_voice_valid = 0;
      i_mix_rdy = 0;
      if (rst) begin
        vcnt = -1; ecnt = 0; rdy_pend = 0; acc = '0;
      end else begin
        if (vcnt == 0) begin
          i_voice_valid = 1;
          i_voice_data = vdata[vidx];
          vcnt = -1;
        end else if (vcnt > 0) begin
          vcnt--;
        end
        if (o_voice_req) begin
          vidx = (int'(o_voice_idx) < NV) ? int'(o_voice_idx) : 0;
          vcnt = vlat[vidx];
          req_cnt++;
        end
        if (rdy_pend) begin
          i_mix_rdy = 1;
          i_mix_out = acc;
          acc = '0;
          rdy_pend = 0;
        end
        if (o_mix_en) begin
          sh = $signed(o_mix_data) >>> 4;
          acc = acc + sh;
          en_q.push_back(ncyc);
          ecnt++;
          if (ecnt == NV) begin
            ecnt = 0;
            rdy_pend = 1;
          end
        end
        if (o_sample_valid && !prev_v) valid_rise = ncyc;
      end
      prev_v = o_sample_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: per-voice cycle cost and contribution straight from the frame rules.
  task automatic build_ref(output logic [DW-1:0] exp_sum, output int exp_end, output bit exp_to);
    int off;
    int s;
    logic signed [DW-1:0] smp;
    off = 0; s = 0; exp_to = 0;
    exp_q.delete();
    for (int k = 0; k < NV; k++) begin
      if (vmute[k]) begin
        off += 2; smp = '0;
      end else if (vlat[k] < TO) begin
        off += 3 + vlat[k]; smp = vdata[k];
      end else begin
        off += 2 + TO; smp = '0; exp_to = 1;
      end
      exp_q.push_back(32'(off));
      s += int'(smp >>> 4);
    end
    exp_sum = s[DW-1:0];
    exp_end = off;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clr_errors();
    @(posedge clk); #1 i_clr_err = 1;
    @(posedge clk); #1 i_clr_err = 0;
  endtask

  task automatic run_frame(input string tag, input int extra_tick, input bit clr_with_tick, input bit accept);
    logic [DW-1:0] exp_sum;
    int exp_end;
    bit exp_to;
    int base;
    int total;
    bit was_valid;
    build_ref(exp_sum, exp_end, exp_to);
    en_q.delete();
    valid_rise = -1;
    req_cnt = 0;
    @(posedge clk); #1;
    was_valid = o_sample_valid;
    i_tick = 1;
    base = ncyc + 1;
    total = exp_end + 4;
    for (int c = 0; c < total; c++) begin
      @(posedge clk); #1;
      i_tick = (c == extra_tick);
      i_clr_err = (c == extra_tick) && clr_with_tick;
    end
    i_tick = 0;
    i_clr_err = 0;
    check({tag, "_en_count"}, 32'(en_q.size()), 32'(NV));
    for (int i = 0; i < NV; i++) begin
      if (i < en_q.size()) check($sformatf("%s_en%0d_cycle", tag, i), 32'(en_q[i] - base), exp_q[i]);
    end
    check({tag, "_req_count"}, 32'(req_cnt), 32'(NV - $countones(vmute)));
    check({tag, "_sample"}, 32'(o_sample), 32'(exp_sum));
    check({tag, "_valid"}, 32'(o_sample_valid), 32'd1);
    check({tag, "_busy_end"}, 32'(o_busy), 32'd0);
    check({tag, "_timeout"}, 32'(o_timeout), 32'(exp_to));
    if (!was_valid) check({tag, "_valid_cycle"}, 32'(valid_rise - base), 32'(exp_end + 2));
    if (extra_tick >= 0) check({tag, "_overrun"}, 32'(o_overrun), 32'd1);
    if (accept) begin
      i_sample_ready = 1;
      @(posedge clk); #1;
      i_sample_ready = 0;
      check({tag, "_valid_cleared"}, 32'(o_sample_valid), 32'd0);
      check({tag, "_sample_held"}, 32'(o_sample), 32'(exp_sum));
    end
  endtask

  task automatic set_all(input logic [DW-1:0] d, input int lat);
    for (int k = 0; k < NV; k++) begin
      vdata[k] = d;
      vlat[k] = lat;
    end
  endtask

  task automatic randomize_frame();
    for (int k = 0; k < NV; k++) begin
      vdata[k] = 24'($urandom());
      vlat[k] = $urandom_range(0, 16);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1; i_tick = 0; i_sample_ready = 0; i_clr_err = 0;
    set_all(24'h000100, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_voice_req", 32'(o_voice_req), 32'd0);
    check("rst_voice_idx", 32'(o_voice_idx), 32'd0);
    check("rst_mix_en", 32'(o_mix_en), 32'd0);
    check("rst_mix_data", 32'(o_mix_data), 32'd0);
    check("rst_sample", 32'(o_sample), 32'd0);
    check("rst_sample_valid", 32'(o_sample_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    rst = 0;

    // Nominal frame: 10 x (0x100 >>> 4) = 0xA0, enables at 3,6,..,30, valid at 32.
    run_frame("basic", -1, 0, 1);
    check("basic_const_sum", 32'(o_sample), 32'h0000A0);

    // Voice 4 silent: zero pushed after 15 WAIT cycles, timeout sticky until cleared.
    set_all(24'h000100, 0);
    vlat[4] = 255;
    run_frame("timeout", -1, 0, 1);
    check("timeout_overrun_clear", 32'(o_overrun), 32'd0);
    clr_errors();
    check("timeout_cleared", 32'(o_timeout), 32'd0);

    // Tick while busy, with clear in the same cycle: set wins, frame intact.
    set_all(24'h012340, 1);
    run_frame("busy_tick", 10, 1, 1);
    clr_errors();
    check("busy_overrun_cleared", 32'(o_overrun), 32'd0);

    // Tick on the DRAIN->IDLE edge (cycle 31 with all latencies 0) is dropped.
    set_all(24'hFFF000, 0);
    run_frame("drain_tick", 30, 0, 1);
    clr_errors();

    // Unaccepted result overwritten by the next frame.
    randomize_frame();
    run_frame("ow1", -1, 0, 0);
    check("ow1_no_overrun", 32'(o_overrun), 32'd0);
    randomize_frame();
    run_frame("ow2", -1, 0, 1);
    check("ow2_overrun", 32'(o_overrun), 32'd1);
    clr_errors();

    // Random frames; first one pins latencies at the 14/15 timeout boundary.
    for (int f = 0; f < 6; f++) begin
      randomize_frame();
      if (f == 0) begin
        vlat[0] = 15;
        vlat[9] = 14;
      end
      run_frame($sformatf("rnd%0d", f), -1, 0, 1);
      clr_errors();
    end

    // Reset during voice 6 request (cycle 19 with zero latency).
    set_all(24'h000200, 0);
    @(posedge clk); #1;
    i_tick = 1;
    @(posedge clk); #1;
    i_tick = 0;
    repeat (18) @(posedge clk);
    #1;
    check("midrst_idx_before", 32'(o_voice_idx), 32'd6);
    rst = 1;
    #1;
    en_q.delete();
    check("midrst_voice_req", 32'(o_voice_req), 32'd0);
    check("midrst_voice_idx", 32'(o_voice_idx), 32'd0);
    check("midrst_mix_en", 32'(o_mix_en), 32'd0);
    check("midrst_mix_data", 32'(o_mix_data), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_sample_valid", 32'(o_sample_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_enables", 32'(en_q.size()), 32'd0);
    randomize_frame();
    run_frame("post_rst", -1, 0, 1);
    clr_errors();

`ifdef MIXER_SEQ_MUTE_MASK_EN
    set_all(24'h000100, 0);
    vmute = 10'b0000000101;
    run_frame("mute", -1, 0, 1);
    vmute = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mixer_sequencer.md
# mixer_sequencer

Frame sequencer in front of the 10-voice mixer. On each sample-rate tick it polls voice slots 0..9 in turn, feeds each returned sample to the mixer with a one-cycle enable, and captures the mixed result. It then presents the result to the audio output stage through a valid/ready handshake. It is the only driver of the mixer's enable and data inputs, and it keeps the mixer's internal 10-count aligned to frame boundaries.

## Interface
- NUM_VOICES, 10: voices per frame; must equal the mixer's fixed count of 10.
- DATA_W, 24: sample width, signed two's complement.
- TIMEOUT_CYC, 15: maximum WAIT cycles per voice before zero substitution; range 1..255.

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high; must also reset the mixer
- i_tick  in  1  sample-rate strobe, one cycle wide
- o_voice_req  out  1  one-cycle request to the voice engine
- o_voice_idx  out  4  slot being polled, 0..9
- i_voice_valid  in  1  voice sample valid, acknowledges o_voice_req
- i_voice_data  in  DATA_W  voice sample
- o_mix_en  out  1  mixer clock enable, one cycle per voice
- o_mix_data  out  DATA_W  mixer input sample
- i_mix_rdy  in  1  mixer result strobe
- i_mix_out  in  DATA_W  mixer result
- o_sample  out  DATA_W  frame result
- o_sample_valid  out  1  frame result valid
- i_sample_ready  in  1  downstream accept
- o_busy  out  1  high in any state other than IDLE
- o_timeout  out  1  sticky: at least one voice timed out
- o_overrun  out  1  sticky: a tick was missed or an unaccepted sample was overwritten
- i_clr_err  in  1  synchronous clear of o_timeout and o_overrun

## Operation
- Reset values: all outputs 0; state IDLE; o_voice_idx 0; data registers 0.
- State IDLE:
  - i_tick moves the block to REQ and sets idx to 0.
- State REQ (1 cycle):
  - o_voice_req is 1 with o_voice_idx = idx.
  - Next state WAIT; the timeout counter is cleared.
- State WAIT:
  - If i_voice_valid is 1, i_voice_data is captured and the next state is PUSH.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYC, zero is captured, o_timeout is set, and the next state is PUSH.
  - i_voice_valid outside WAIT is ignored.
- State PUSH (1 cycle):
  - o_mix_en is 1 and o_mix_data holds the captured sample.
  - If idx == NUM_VOICES-1, next state is DRAIN. Otherwise idx increments and the next state is REQ.
- State DRAIN:
  - Waits for i_mix_rdy. On i_mix_rdy, i_mix_out is loaded into o_sample, o_sample_valid is set, and the next state is IDLE.
- o_mix_en is 0 in every state except PUSH. The mixer receives exactly NUM_VOICES enables per frame, so a frame is never aborted except by rst.
- Output handshake:
  - o_sample_valid and o_sample stay stable until i_sample_ready is sampled high, which clears o_sample_valid.
  - If DRAIN loads a new result while o_sample_valid is 1 and i_sample_ready is 0, the new result overwrites the old one, o_sample_valid stays 1, and o_overrun is set.
- i_tick while o_busy is 1 is dropped and sets o_overrun.
- i_tick coincident with the DRAIN→IDLE transition is also dropped, because the tick is sampled in the cycle the block is not yet in IDLE.
- Error flags:
  - i_clr_err clears o_timeout and o_overrun.
  - If a set event and i_clr_err occur in the same cycle, the set wins.
- Reset mid-frame returns the block to IDLE, with the mixer cleared by the same rst.

## Timing
- i_tick is sampled at edge E0; REQ occupies cycle 1.
- Voice valid returned in the first WAIT cycle gives 3 cycles per voice, so voice k has o_mix_en in cycle 3+3k.
- The last o_mix_en is in cycle 30. i_mix_rdy arrives in cycle 31, and o_sample_valid is 1 from cycle 32.
- Minimum tick period: 32 cycles. Each WAIT extension adds 1 cycle per voice.
- Worst case per voice: 2 + TIMEOUT_CYC cycles.

## Configuration
- MIXER_SEQ_MUTE_MASK_EN defined:
  - Adds input i_mute, width NUM_VOICES.
  - In REQ, i_mute[idx] is sampled. A muted slot asserts no o_voice_req, skips WAIT, and goes directly to PUSH with o_mix_data = 0, taking 2 cycles.
  - The mixer still receives NUM_VOICES enables.
- MIXER_SEQ_MUTE_MASK_EN undefined:
  - No i_mute port; every slot is requested.

## Test plan
- Reset, then tick with every voice returning data 0x000100 in the cycle after req:
  - o_mix_en pulses in cycles 3, 6, …, 30.
  - o_sample = 10×(0x000100>>>4) = 0x0000A0, valid in cycle 32.
- Voice 4 never returns valid and TIMEOUT_CYC = 15:
  - Slot 4 pushes 0 after 15 WAIT cycles and o_timeout = 1.
  - The frame completes with 10 enables.
  - i_clr_err then clears o_timeout.
- Second tick while o_busy is 1:
  - The tick is ignored, o_overrun = 1, and the current frame is unaffected.
- i_sample_ready held at 0 across two frames:
  - The second frame overwrites o_sample, o_sample_valid stays 1, and o_overrun = 1.
  - Raising i_sample_ready clears valid one cycle later.
- rst asserted during voice 6:
  - All outputs are 0 immediately, with no further o_mix_en.
  - The next tick produces a correct full frame.
- With MIXER_SEQ_MUTE_MASK_EN and i_mute = 10'b0000000101:
  - Slots 0 and 2 assert no o_voice_req and push 0.
  - The frame ends 2 cycles earlier, in cycle 30.
